// File: rtl/reg_addr_sequencer_pkg.sv
// Shared datapath constants for the register-address sequencer: mode codes,
// sequencer states, fixed register numbers and a population-count helper.
package reg_addr_sequencer_pkg;

  localparam logic [2:0] SEL_RN   = 3'd0;
  localparam logic [2:0] SEL_RD   = 3'd1;
  localparam logic [2:0] SEL_RM   = 3'd2;
  localparam logic [2:0] SEL_PC   = 3'd3;
  localparam logic [2:0] SEL_LR   = 3'd4;
  localparam logic [2:0] SEL_LIST = 3'd5;

  localparam int REG_PC = 15;
  localparam int REG_LR = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/reg_addr_sequencer_ffs_encoder.sv
// Lowest-set-bit index of a vector plus an any-bit-set flag; purely combinational.
module ffs_encoder #(
  parameter int LIST_W = 16,
  parameter int IDX_W  = $clog2(LIST_W)
) (
  input  logic [LIST_W-1:0] vec,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_addr_sequencer.sv
// Registered register-file address generator: instruction field / constant
// selection, plus a list mode that walks a register bitmask lowest-first.
module reg_addr_sequencer
  import reg_addr_sequencer_pkg::*;
#(
  parameter int REG_W  = 4,
  parameter int IR_W   = 32,
  parameter int LIST_W = 16,
  parameter int RN_LSB = 16,
  parameter int RD_LSB = 12,
  parameter int RM_LSB = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IR_W-1:0]   ir,
  input  logic [2:0]        sel,
  input  logic              start,
  input  logic              step,
  input  logic              abort,
  output logic [REG_W-1:0]  addr_out,
  output logic              addr_valid,
  output logic              busy,
  output logic              done,
  output logic [REG_W:0]    count
);

  localparam logic [REG_W-1:0] PC_ADDR = REG_W'(REG_PC);
  localparam logic [REG_W-1:0] LR_ADDR = REG_W'(REG_LR);

  state_t              state, state_n;
  logic [LIST_W-1:0]   mask, mask_n;
  logic [REG_W-1:0]    addr_n;
  logic                valid_n, busy_n, done_n;
  logic [REG_W:0]      count_n;

  logic [LIST_W-1:0]   list_in;
  logic [LIST_W-1:0]   rest;
  logic [LIST_W-1:0]   enc_vec;
  logic [REG_W-1:0]    enc_idx;
  logic                enc_any;
  logic                unused_ir;

  assign list_in   = ir[LIST_W-1:0];
  assign unused_ir = ^ir;

  // Remaining list once the address currently presented is consumed.
  assign rest = mask & ~(LIST_W'(1) << addr_out);

  // One encoder serves both the first address (from ir) and each next address.
  assign enc_vec = (state == IDLE) ? list_in : rest;

  ffs_encoder #(
    .LIST_W (LIST_W),
    .IDX_W  (REG_W)
  ) u_ffs (
    .vec (enc_vec),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mask       <= '0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
    end else begin
      state      <= state_n;
      mask       <= mask_n;
      addr_out   <= addr_n;
      addr_valid <= valid_n;
      busy       <= busy_n;
      done       <= done_n;
      count      <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    mask_n  = mask;
    addr_n  = addr_out;
    valid_n = addr_valid;
    busy_n  = busy;
    done_n  = 1'b0;
    count_n = count;

    unique case (state)
      IDLE: begin
        busy_n  = 1'b0;
        addr_n  = '0;
        valid_n = 1'b0;
        case (sel)
          SEL_RN: begin addr_n = ir[RN_LSB +: REG_W]; valid_n = 1'b1; end
          SEL_RD: begin addr_n = ir[RD_LSB +: REG_W]; valid_n = 1'b1; end
          SEL_RM: begin addr_n = ir[RM_LSB +: REG_W]; valid_n = 1'b1; end
          SEL_PC: begin addr_n = PC_ADDR;             valid_n = 1'b1; end
          SEL_LR: begin addr_n = LR_ADDR;             valid_n = 1'b1; end
          SEL_LIST: begin
            if (start) begin
              mask_n  = list_in;
              count_n = (REG_W+1)'(popcount32(32'(list_in)));
              if (enc_any) begin
                state_n = RUN;
                addr_n  = enc_idx;
                valid_n = 1'b1;
                busy_n  = 1'b1;
              end else begin
                state_n = FIN;
                done_n  = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end

      RUN: begin
        if (abort) begin
          state_n = IDLE;
          mask_n  = '0;
          addr_n  = '0;
          valid_n = 1'b0;
          busy_n  = 1'b0;
        end else if (step && addr_valid) begin
          mask_n = rest;
          if (enc_any) begin
            addr_n = enc_idx;
          end else begin
            state_n = FIN;
            addr_n  = '0;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end

      FIN: begin
        state_n = IDLE;
        mask_n  = '0;
        addr_n  = '0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = IDLE;
        mask_n  = '0;
        addr_n  = '0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
